stack_seq: RTL

- Sequencer for the Forth data stack: executes PUSH, POP, DUP, DROP, SWAP and OVER on a single-port EBR stack RAM.
- Holds TOS in a register and keeps NOS and deeper cells in RAM.
- Turns each Forth stack op into 1–2 RAM cycles behind a valid/ready request port.
- Sits between the ForthSuper inner interpreter and the EBR stack instance.

---
 rtl/stack_seq_pkg.sv | 20 ++
 rtl/stack_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/stack_seq_pkg.sv
// Shared types for the Forth data-stack sequencer: command encoding and FSM states.
package stack_seq_pkg;

    typedef enum logic [2:0] {
        SS_NOP  = 3'd0,
        SS_PUSH = 3'd1,
        SS_POP  = 3'd2,
        SS_DUP  = 3'd3,
        SS_DROP = 3'd4,
        SS_SWAP = 3'd5,
        SS_OVER = 3'd6
    } ss_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_COMMIT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/stack_seq.sv
// Forth data-stack sequencer: TOS held in a register, NOS and deeper cells in a
// single-port synchronous-read RAM; each stack op becomes one or two RAM cycles.
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    parameter int SSZ   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  ss_cmd_t        req_op,
    input  logic [DSZ-1:0] req_v,
    output logic           rsp_valid,
    output logic [DSZ-1:0] rsp_v,
    output logic           err,
    output logic [DSZ-1:0] tos,
    output logic [SSZ:0]   depth,
    output logic [SSZ-1:0] ram_addr,
    output logic           ram_we,
    output logic [DSZ-1:0] ram_wd,
    input  logic [DSZ-1:0] ram_rd
);

    localparam logic [SSZ-1:0] SP_ONE = SSZ'(1);
    localparam logic [SSZ:0]   D_ONE  = (SSZ+1)'(1);
    localparam logic [SSZ:0]   D_TWO  = (SSZ+1)'(2);
    localparam logic [SSZ:0]   D_FULL = (SSZ+1)'(DEPTH);

    seq_state_t     state;
    ss_cmd_t        op_q;
    logic [SSZ-1:0] sp;
    logic           underflow;
    logic           overflow;

    always_comb begin
        underflow = 1'b0;
        overflow  = 1'b0;
        case (req_op)
            SS_POP, SS_DROP: underflow = (depth < D_ONE);
            SS_SWAP:         underflow = (depth < D_TWO);
            SS_DUP: begin
                underflow = (depth < D_ONE);
                overflow  = (depth == D_FULL);
            end
            SS_OVER: begin
                underflow = (depth < D_TWO);
                overflow  = (depth == D_FULL);
            end
            SS_PUSH:         overflow  = (depth == D_FULL);
            default: ;
        endcase
    end

    assign req_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= SS_NOP;
            sp        <= '1;
            tos       <= '0;
            depth     <= '0;
            rsp_valid <= 1'b0;
            rsp_v     <= '0;
            err       <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wd    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            ram_we    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (underflow || overflow) begin
                            rsp_valid <= 1'b1;
                            err       <= 1'b1;
                        end else begin
                            case (req_op)
                                SS_PUSH: begin
                                    // an empty stack has no old TOS to spill
                                    if (depth != '0) begin
                                        ram_we   <= 1'b1;
                                        ram_addr <= sp + SP_ONE;
                                        ram_wd   <= tos;
                                        sp       <= sp + SP_ONE;
                                    end
                                    tos       <= req_v;
                                    depth     <= depth + D_ONE;
                                    rsp_valid <= 1'b1;
                                end
                                SS_DUP: begin
                                    ram_we    <= 1'b1;
                                    ram_addr  <= sp + SP_ONE;
                                    ram_wd    <= tos;
                                    sp        <= sp + SP_ONE;
                                    depth     <= depth + D_ONE;
                                    rsp_valid <= 1'b1;
                                end
                                SS_POP, SS_DROP: begin
                                    if (depth == D_ONE) begin
                                        if (req_op == SS_POP)
                                            rsp_v <= tos;
                                        tos       <= '0;
                                        depth     <= '0;
                                        rsp_valid <= 1'b1;
                                    end else begin
                                        ram_addr <= sp;
                                        op_q     <= req_op;
                                        state    <= ST_FETCH;
                                    end
                                end
                                SS_SWAP, SS_OVER: begin
                                    ram_addr <= sp;
                                    op_q     <= req_op;
                                    state    <= ST_FETCH;
                                end
                                default: rsp_valid <= 1'b1;
                            endcase
                        end
                    end
                end
                ST_FETCH: state <= ST_COMMIT;
                ST_COMMIT: begin
                    // NOS read data is on ram_rd during this cycle
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b1;
                    tos       <= ram_rd;
                    case (op_q)
                        SS_POP: begin
                            rsp_v <= tos;
                            sp    <= sp - SP_ONE;
                            depth <= depth - D_ONE;
                        end
                        SS_DROP: begin
                            sp    <= sp - SP_ONE;
                            depth <= depth - D_ONE;
                        end
                        SS_SWAP: begin
                            ram_we   <= 1'b1;
                            ram_addr <= sp;
                            ram_wd   <= tos;
                        end
                        SS_OVER: begin
                            ram_we   <= 1'b1;
                            ram_addr <= sp + SP_ONE;
                            ram_wd   <= tos;
                            sp       <= sp + SP_ONE;
                            depth    <= depth + D_ONE;
                        end
                        default: ;
                    endcase
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
